// File: rtl/sram_access_ctrl.sv
// SRAM macro access sequencer: precharge -> wordline/write-drive -> sense -> read-data capture.
// All array-facing controls are registered so the mixed-signal phases never overlap.
module sram_access_ctrl #(
    parameter int COLS    = 16,
    parameter int ROWS    = 16,
    parameter int ADDR_W  = 4,
    parameter int PRE_CYC = 1,
    parameter int RD_CYC  = 2,
    parameter int WR_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [COLS-1:0]   req_wdata,
    output logic              precharge_en,
    output logic [ROWS-1:0]   wl_sel,
    output logic              wr_en,
    output logic [COLS-1:0]   wr_data,
    output logic              sa_en,
    input  logic [COLS-1:0]   preout,
    output logic              rd_valid,
    output logic [COLS-1:0]   rd_data
);

    localparam int MAX_AB = (PRE_CYC > RD_CYC) ? PRE_CYC : RD_CYC;
    localparam int MAXC   = (MAX_AB > WR_CYC) ? MAX_AB : WR_CYC;
    localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRECH,
        ACCESS,
        SENSE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLS-1:0]    wdata_q, wdata_d;
    logic               addr_ok;
    logic               accept;
    logic [ROWS-1:0]    wl_dec;

    logic               precharge_d;
    logic [ROWS-1:0]    wl_sel_d;
    logic               wr_en_d;
    logic [COLS-1:0]    wr_data_d;
    logic               sa_en_d;
    logic               rd_valid_d;
    logic [COLS-1:0]    rd_data_d;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign addr_ok   = int'(addr_q) < ROWS;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = PRECH;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            PRECH: begin
                if (cnt_q == PRE_LAST) state_d = ACCESS;
            end
            ACCESS: begin
                if (we_q) begin
                    if (cnt_q == WR_LAST) state_d = IDLE;
                end else begin
                    if (cnt_q == RD_LAST) state_d = SENSE;
                end
            end
            SENSE: begin
                state_d    = IDLE;
                rd_valid_d = 1'b1;
                // Unmapped rows never had a wordline raised, so the bitlines carry nothing.
                rd_data_d  = addr_ok ? preout : '0;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Rows beyond ROWS have no decode bit, so out-of-range addresses select nothing.
    always_comb begin
        wl_dec = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (addr_d == ADDR_W'(i)) wl_dec[i] = 1'b1;
        end
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        precharge_d = (state_d == PRECH);
        wl_sel_d    = ((state_d == ACCESS) || (state_d == SENSE)) ? wl_dec : '0;
        wr_en_d     = (state_d == ACCESS) && we_d;
        wr_data_d   = wr_en_d ? wdata_d : '0;
        sa_en_d     = (state_d == SENSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            precharge_en <= 1'b0;
            wl_sel       <= '0;
            wr_en        <= 1'b0;
            wr_data      <= '0;
            sa_en        <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            precharge_en <= precharge_d;
            wl_sel       <= wl_sel_d;
            wr_en        <= wr_en_d;
            wr_data      <= wr_data_d;
            sa_en        <= sa_en_d;
            rd_valid     <= rd_valid_d;
            rd_data      <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: a per-cycle vector table on the default instance, plus
// hand sequences and a reference-model random run on a ROWS=12, PRE=2/RD=3/WR=1 instance.
module tb_sram_access_ctrl;

    localparam int P1 = 2;
    localparam int R1 = 3;
    localparam int W1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance 0: default parameters
    logic        rst0, valid0, we0, ready0, pre0, wen0, sa0, rdv0;
    logic [3:0]  addr0;
    logic [15:0] wdata0, preout0, wl0, wd0, rdd0;

    // instance 1: 12 rows, longer phases
    logic        rst1, valid1, we1, ready1, pre1, wen1, sa1, rdv1;
    logic [3:0]  addr1;
    logic [15:0] wdata1, preout1, wd1, rdd1;
    logic [11:0] wl1;

    sram_access_ctrl dut0 (
        .clk(clk), .rst(rst0), .req_valid(valid0), .req_ready(ready0), .req_we(we0),
        .req_addr(addr0), .req_wdata(wdata0), .precharge_en(pre0), .wl_sel(wl0),
        .wr_en(wen0), .wr_data(wd0), .sa_en(sa0), .preout(preout0),
        .rd_valid(rdv0), .rd_data(rdd0)
    );

    sram_access_ctrl #(
        .COLS(16), .ROWS(12), .ADDR_W(4), .PRE_CYC(P1), .RD_CYC(R1), .WR_CYC(W1)
    ) dut1 (
        .clk(clk), .rst(rst1), .req_valid(valid1), .req_ready(ready1), .req_we(we1),
        .req_addr(addr1), .req_wdata(wdata1), .precharge_en(pre1), .wl_sel(wl1),
        .wr_en(wen1), .wr_data(wd1), .sa_en(sa1), .preout(preout1),
        .rd_valid(rdv1), .rd_data(rdd1)
    );

    typedef struct {
        logic        rst, valid, we;
        logic [3:0]  addr;
        logic [15:0] wdata, preout;
        logic        rdy, pre;
        logic [15:0] wl;
        logic        wen;
        logic [15:0] wd;
        logic        sa, rdv;
        logic [15:0] rdd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic valid, input logic we,
                               input logic [3:0] addr, input logic [15:0] wdata,
                               input logic [15:0] preout, input logic rdy, input logic pre,
                               input logic [15:0] wl, input logic wen, input logic [15:0] wd,
                               input logic sa, input logic rdv, input logic [15:0] rdd);
        vec_t r;
        r.rst = rst; r.valid = valid; r.we = we; r.addr = addr; r.wdata = wdata;
        r.preout = preout; r.rdy = rdy; r.pre = pre; r.wl = wl; r.wen = wen; r.wd = wd;
        r.sa = sa; r.rdv = rdv; r.rdd = rdd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reads on instance 1; the first loads rd_data so the out-of-range read must clear it.
    task automatic read1(input logic [3:0] addr, input logic [11:0] exp_wl,
                         input logic [15:0] exp_rdd);
        valid1 = 1'b1; we1 = 1'b0; addr1 = addr; preout1 = 16'hFFFF;
        #1;
        check($sformatf("rd1_a%0d.accept_rdy", addr), 32'(ready1), 32'd1);
        step();
        valid1 = 1'b0;
        for (int k = 1; k <= P1 + R1 + 3; k++) begin
            #1;
            check($sformatf("rd1_a%0d.k%0d.pre", addr, k), 32'(pre1), 32'(k <= P1));
            check($sformatf("rd1_a%0d.k%0d.wl", addr, k), 32'(wl1),
                  32'((k > P1 && k <= P1 + R1 + 1) ? exp_wl : 12'h000));
            check($sformatf("rd1_a%0d.k%0d.sa", addr, k), 32'(sa1), 32'(k == P1 + R1 + 1));
            check($sformatf("rd1_a%0d.k%0d.rdv", addr, k), 32'(rdv1), 32'(k == P1 + R1 + 2));
            check($sformatf("rd1_a%0d.k%0d.rdy", addr, k), 32'(ready1), 32'(k >= P1 + R1 + 2));
            if (k >= P1 + R1 + 2)
                check($sformatf("rd1_a%0d.k%0d.rdd", addr, k), 32'(rdd1), 32'(exp_rdd));
            step();
        end
    endtask

    // reference model state for the random run on instance 1
    logic        m_busy, m_we, m_rdv;
    int          m_k;
    logic [3:0]  m_addr;
    logic [15:0] m_wdata, m_rdd;

    initial begin
        rst0 = 1'b1; valid0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; preout0 = '0;
        rst1 = 1'b1; valid1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; preout1 = '0;
        step();
        step();

        //        rst v we addr wdata     preout    rdy pre wl        wen wd        sa rdv rdd
        tbl.push_back(v(1, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 1, 0, 3,  16'h0000, 16'hA5C3, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 3,  16'h0000, 16'hA5C3, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 3,  16'h0000, 16'hA5C3, 0, 0, 16'h0008, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 3,  16'h0000, 16'hA5C3, 0, 0, 16'h0008, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 3,  16'h0000, 16'hA5C3, 0, 0, 16'h0008, 0, 16'h0000, 1, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'hA5C3));
        tbl.push_back(v(0, 1, 1, 15, 16'h1234, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'hA5C3));
        tbl.push_back(v(0, 0, 1, 15, 16'h1234, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'hA5C3));
        tbl.push_back(v(0, 1, 0, 2,  16'hFFFF, 16'h0000, 0, 0, 16'h8000, 1, 16'h1234, 0, 0, 16'hA5C3));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 16'h8000, 1, 16'h1234, 0, 0, 16'hA5C3));
        tbl.push_back(v(0, 1, 0, 0,  16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'hA5C3));
        tbl.push_back(v(0, 1, 0, 1,  16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'hA5C3));
        tbl.push_back(v(0, 1, 0, 1,  16'h0000, 16'h0000, 0, 0, 16'h0001, 0, 16'h0000, 0, 0, 16'hA5C3));
        tbl.push_back(v(0, 1, 0, 1,  16'h0000, 16'h0000, 0, 0, 16'h0001, 0, 16'h0000, 0, 0, 16'hA5C3));
        tbl.push_back(v(0, 1, 0, 1,  16'h0000, 16'h1111, 0, 0, 16'h0001, 0, 16'h0000, 1, 0, 16'hA5C3));
        tbl.push_back(v(0, 1, 0, 1,  16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1111));
        tbl.push_back(v(0, 0, 0, 1,  16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h1111));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 16'h0002, 0, 16'h0000, 0, 0, 16'h1111));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 16'h0002, 0, 16'h0000, 0, 0, 16'h1111));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'h2222, 0, 0, 16'h0002, 0, 16'h0000, 1, 0, 16'h1111));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h2222));
        tbl.push_back(v(0, 1, 0, 5,  16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h2222));
        tbl.push_back(v(0, 0, 0, 5,  16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h2222));
        tbl.push_back(v(1, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 16'h0020, 0, 16'h0000, 0, 0, 16'h2222));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'hFFFF, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'hFFFF, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'hFFFF, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 1, 0, 7,  16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 7,  16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 7,  16'h0000, 16'h0000, 0, 0, 16'h0080, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 7,  16'h0000, 16'h0000, 0, 0, 16'h0080, 0, 16'h0000, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 7,  16'h0000, 16'hBEEF, 0, 0, 16'h0080, 0, 16'h0000, 1, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'hBEEF));
        tbl.push_back(v(0, 0, 0, 0,  16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'hBEEF));

        foreach (tbl[i]) begin
            rst0 = tbl[i].rst; valid0 = tbl[i].valid; we0 = tbl[i].we;
            addr0 = tbl[i].addr; wdata0 = tbl[i].wdata; preout0 = tbl[i].preout;
            #1;
            check($sformatf("r%0d.rdy", i), 32'(ready0), 32'(tbl[i].rdy));
            check($sformatf("r%0d.pre", i), 32'(pre0), 32'(tbl[i].pre));
            check($sformatf("r%0d.wl", i), 32'(wl0), 32'(tbl[i].wl));
            check($sformatf("r%0d.wen", i), 32'(wen0), 32'(tbl[i].wen));
            check($sformatf("r%0d.wd", i), 32'(wd0), 32'(tbl[i].wd));
            check($sformatf("r%0d.sa", i), 32'(sa0), 32'(tbl[i].sa));
            check($sformatf("r%0d.rdv", i), 32'(rdv0), 32'(tbl[i].rdv));
            check($sformatf("r%0d.rdd", i), 32'(rdd0), 32'(tbl[i].rdd));
            step();
        end

        rst1 = 1'b0;
        #1;
        check("i1.reset_rdd", 32'(rdd1), 32'd0);
        check("i1.reset_rdy", 32'(ready1), 32'd1);
        read1(4'd4, 12'h010, 16'hFFFF);
        read1(4'd13, 12'h000, 16'h0000);

        m_busy = 1'b0; m_we = 1'b0; m_rdv = 1'b0; m_k = 0;
        m_addr = '0; m_wdata = '0; m_rdd = 16'h0000;
        for (int c = 0; c < 10000; c++) begin
            logic [11:0] e_wl;
            logic        act;
            rst1    = ($urandom_range(0, 299) == 0);
            valid1  = ($urandom_range(0, 2) != 0);
            we1     = $urandom_range(0, 1) == 1;
            addr1   = 4'($urandom_range(0, 15));
            wdata1  = 16'($urandom);
            preout1 = 16'($urandom);
            #1;
            act  = m_busy && (m_k > P1);
            e_wl = '0;
            if (act && m_addr < 4'd12) e_wl[m_addr] = 1'b1;
            check("rnd.rdy", 32'(ready1), 32'(!m_busy && !rst1));
            check("rnd.pre", 32'(pre1), 32'(m_busy && m_k <= P1));
            check("rnd.wl", 32'(wl1), 32'(e_wl));
            check("rnd.wen", 32'(wen1), 32'(act && m_we));
            check("rnd.wd", 32'(wd1), 32'((act && m_we) ? m_wdata : 16'h0000));
            check("rnd.sa", 32'(sa1), 32'(m_busy && !m_we && m_k == P1 + R1 + 1));
            check("rnd.rdv", 32'(rdv1), 32'(m_rdv));
            check("rnd.rdd", 32'(rdd1), 32'(m_rdd));
            check("rnd.excl_pre", 32'(pre1 && ((|wl1) || wen1 || sa1)), 32'd0);
            check("rnd.excl_wrsa", 32'(wen1 && sa1), 32'd0);
            check("rnd.onehot", 32'($onehot0(wl1)), 32'd1);
            step();
            if (rst1) begin
                m_busy = 1'b0; m_rdv = 1'b0; m_rdd = 16'h0000;
            end else begin
                m_rdv = 1'b0;
                if (!m_busy) begin
                    if (valid1) begin
                        m_busy = 1'b1; m_k = 1;
                        m_we = we1; m_addr = addr1; m_wdata = wdata1;
                    end
                end else if (!m_we && m_k == P1 + R1 + 1) begin
                    m_busy = 1'b0; m_rdv = 1'b1;
                    m_rdd = (m_addr < 4'd12) ? preout1 : 16'h0000;
                end else if (m_we && m_k == P1 + W1) begin
                    m_busy = 1'b0;
                end else begin
                    m_k++;
                end
            end
            if (errors > 50) break;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
